// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: architectural width, reset PC, bubble word,
// the fetch-stage state encoding and the sequential-PC helper.
package pipeline_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } fetch_state_t;

   // Sequential PC; wraps 0xFFFF_FFFC -> 0x0000_0000 silently.
   function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc_in);
      return pc_in + 32'd4;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst_n        : clock, async active-low reset
//   load              : capture instr_d/pc_d, mark valid
//   flush             : insert bubble (NOP_INSTR, valid=0), PC kept; beats load
//   instr_d, pc_d     : next instruction word and its PC
//   instruction, pc,
//   valid             : registered IF/ID contents presented to ID
module if_id_reg #(
   parameter logic [31:0] RESET_PC  = pipeline_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         load,
   input  logic                         flush,
   input  logic [pipeline_pkg::XLEN-1:0] instr_d,
   input  logic [pipeline_pkg::XLEN-1:0] pc_d,
   output logic [pipeline_pkg::XLEN-1:0] instruction,
   output logic [pipeline_pkg::XLEN-1:0] pc,
   output logic                         valid
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instruction <= NOP_INSTR;
         pc          <= RESET_PC;
         valid       <= 1'b0;
      end else if (flush) begin
         instruction <= NOP_INSTR;
         valid       <= 1'b0;
      end else if (load) begin
         instruction <= instr_d;
         pc          <= pc_d;
         valid       <= 1'b1;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, instruction-memory request handshake,
// one-entry skid buffer for words returned while ID is stalled, and
// branch redirect handling, feeding the IF/ID register.
//   clk, rst_n                  : clock, async active-low reset
//   pc_load, if_id_load         : hazard-unit enables for PC and IF/ID
//   branch_taken, branch_target : redirect from EX (target[1:0] ignored)
//   imem_req, imem_addr         : memory read request, address = PC
//   imem_ready, imem_rdata      : memory completion and returned word
//   instruction, pc, valid      : IF/ID contents
//
// state | meaning
// FETCH | request outstanding at pc_q (request drops only in HOLD/reset)
// HOLD  | word parked in skid buffer, waiting for ID to accept it
// DROP  | redirected while a request was in flight; finish it, discard word
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = pipeline_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         pc_load,
   input  logic                         if_id_load,
   input  logic                         branch_taken,
   input  logic [pipeline_pkg::XLEN-1:0] branch_target,
   output logic                         imem_req,
   output logic [pipeline_pkg::XLEN-1:0] imem_addr,
   input  logic                         imem_ready,
   input  logic [pipeline_pkg::XLEN-1:0] imem_rdata,
   output logic [pipeline_pkg::XLEN-1:0] instruction,
   output logic [pipeline_pkg::XLEN-1:0] pc,
   output logic                         valid
);

   import pipeline_pkg::*;

   fetch_state_t    state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pend_pc_q;     // redirect target held while draining in DROP
   logic [XLEN-1:0] skid_instr_q;
   logic [XLEN-1:0] skid_pc_q;
   logic            req_q;

   logic            fire;
   logic [XLEN-1:0] target;
   logic            ifid_load;
   logic [XLEN-1:0] ifid_instr_d;
   logic [XLEN-1:0] ifid_pc_d;

   // A response only counts while our request is up, so a response that
   // straddles a reset is ignored.
   assign fire      = req_q & imem_ready;
   assign target    = branch_target & ~32'h3;
   assign imem_req  = req_q;
   assign imem_addr = pc_q;

   always_comb begin
      ifid_load    = 1'b0;
      ifid_instr_d = imem_rdata;
      ifid_pc_d    = pc_q;
      if (!branch_taken) begin
         case (state_q)
            FETCH: ifid_load = fire & if_id_load;
            HOLD: begin
               ifid_load    = if_id_load;
               ifid_instr_d = skid_instr_q;
               ifid_pc_d    = skid_pc_q;
            end
            default: ifid_load = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         pend_pc_q    <= RESET_PC;
         skid_instr_q <= NOP_INSTR;
         skid_pc_q    <= RESET_PC;
         req_q        <= 1'b0;
      end else begin
         case (state_q)
            FETCH: begin
               req_q <= 1'b1;
               if (branch_taken) begin
                  if (fire) begin
                     pc_q <= target;
                  end else begin
                     pend_pc_q <= target;
                     state_q   <= DROP;
                  end
               end else if (fire) begin
                  if (pc_load)
                     pc_q <= pc_plus4(pc_q);
                  if (!if_id_load) begin
                     skid_instr_q <= imem_rdata;
                     skid_pc_q    <= pc_q;
                     req_q        <= 1'b0;
                     state_q      <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (branch_taken) begin
                  pc_q    <= target;
                  req_q   <= 1'b1;
                  state_q <= FETCH;
               end else if (if_id_load) begin
                  // If the PC was frozen when the word was parked, step past
                  // it now that it has been delivered; otherwise the same
                  // word would be fetched and delivered a second time.
                  if (pc_load && (pc_q == skid_pc_q))
                     pc_q <= pc_plus4(pc_q);
                  req_q   <= 1'b1;
                  state_q <= FETCH;
               end
            end
            DROP: begin
               req_q <= 1'b1;
               if (fire) begin
                  pc_q    <= branch_taken ? target : pend_pc_q;
                  state_q <= FETCH;
               end else if (branch_taken) begin
                  pend_pc_q <= target;
               end
            end
            default: begin
               state_q <= FETCH;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   if_id_reg #(
      .RESET_PC  (RESET_PC),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (ifid_load),
      .flush       (branch_taken),
      .instr_d     (ifid_instr_d),
      .pc_d        (ifid_pc_d),
      .instruction (instruction),
      .pc          (pc),
      .valid       (valid)
   );

endmodule
